// File: rtl/reflet_hub_pkg.sv
// Shared constants for the Reflet peripheral hub: hub register offsets inside region 0
// and the smallest slot size that still holds every hub register.
package reflet_hub_pkg;

    localparam int unsigned HubRegInfo    = 0;
    localparam int unsigned HubRegMask    = 1;
    localparam int unsigned HubRegPending = 2;
    localparam int unsigned HubRegRoute0  = 3;
    localparam int unsigned HubRegRoute1  = 4;

    localparam int unsigned MinSlotSize = 8;

endpackage

// File: rtl/reflet_hub_irq.sv
// Interrupt controller for the peripheral hub: per-slot edge capture, mask, write-1-to-clear
// pending bits and routing of each slot onto one of the registered CPU interrupt lines.
module reflet_hub_irq #(
    parameter int unsigned Slots    = 8,
    parameter int unsigned Width    = 16,
    parameter int unsigned IntLines = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [Slots-1:0]    slot_irq_i,
    input  logic [Width-1:0]    wdata_i,
    input  logic                mask_we_i,
    input  logic                pend_w1c_i,
    input  logic                route0_we_i,
    input  logic                route1_we_i,
    output logic [Slots-1:0]    mask_o,
    output logic [Slots-1:0]    pending_o,
    output logic [Width-1:0]    route0_o,
    output logic [Width-1:0]    route1_o,
    output logic [IntLines-1:0] cpu_int_o
);

    localparam int unsigned RouteW = $clog2(IntLines);

    logic [Slots-1:0]    irq_prev_q, irq_prev_d;
    logic [Slots-1:0]    pending_q, pending_d;
    logic [Slots-1:0]    mask_q, mask_d;
    logic [Width-1:0]    route0_q, route0_d;
    logic [Width-1:0]    route1_q, route1_d;
    logic [IntLines-1:0] cpu_int_q, cpu_int_d;
    logic [2*Width-1:0]  route_all;
    logic [Slots-1:0]    rise;
    logic [Slots-1:0]    clr;

    assign route_all = {route1_q, route0_q};

    always_comb begin
        irq_prev_d = slot_irq_i;
        rise       = slot_irq_i & ~irq_prev_q;
        clr        = pend_w1c_i ? wdata_i[Slots-1:0] : '0;
        // A new edge in the same cycle as a clear of that bit keeps it pending.
        pending_d  = (pending_q & ~clr) | rise;
        mask_d     = mask_we_i ? wdata_i[Slots-1:0] : mask_q;
        route0_d   = route0_we_i ? wdata_i : route0_q;
        route1_d   = route1_we_i ? wdata_i : route1_q;
    end

    always_comb begin
        cpu_int_d = '0;
        for (int s = 0; s < int'(Slots); s++) begin
            if (pending_q[s] && mask_q[s]) begin
                cpu_int_d[route_all[s*RouteW +: RouteW]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            irq_prev_q <= '0;
            pending_q  <= '0;
            mask_q     <= '0;
            route0_q   <= '0;
            route1_q   <= '0;
            cpu_int_q  <= '0;
        end else begin
            irq_prev_q <= irq_prev_d;
            pending_q  <= pending_d;
            mask_q     <= mask_d;
            route0_q   <= route0_d;
            route1_q   <= route1_d;
            cpu_int_q  <= cpu_int_d;
        end
    end

    assign mask_o    = mask_q;
    assign pending_o = pending_q;
    assign route0_o  = route0_q;
    assign route1_o  = route1_q;
    assign cpu_int_o = cpu_int_q;

endmodule

// File: rtl/reflet_periph_hub.sv
// Pipelined peripheral hub: decodes the bus window into uniform slots plus a hub register
// region. The interrupt controller is built only when REFLET_HUB_IRQ_EN is defined.
module reflet_periph_hub
    import reflet_hub_pkg::*;
#(
    parameter int unsigned wordsize       = 16,
    parameter int unsigned base_addr_size = 16,
    parameter int unsigned base_addr      = 16'hFF00,
    parameter int unsigned slots          = 8,
    parameter int unsigned slot_size      = MinSlotSize,
    parameter int unsigned int_lines      = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [base_addr_size-1:0]     addr,
    input  logic [wordsize-1:0]           data_in,
    input  logic                          write_en,
    output logic [wordsize-1:0]           data_out,
    output logic                          ready,
    output logic [slots-1:0]              slot_sel,
    output logic [$clog2(slot_size)-1:0]  slot_addr,
    output logic [wordsize-1:0]           slot_wdata,
    output logic                          slot_we,
    input  logic [slots*wordsize-1:0]     slot_rdata,
    input  logic [slots-1:0]              slot_irq,
    output logic [int_lines-1:0]          cpu_int
);

    localparam int unsigned SlotAw   = $clog2(slot_size);
    localparam int unsigned RegionW  = $clog2(slots + 1);
    localparam int unsigned SlotIdxW = (slots > 1) ? $clog2(slots) : 1;
    localparam int unsigned OffW     = base_addr_size + 1;
    localparam logic [OffW-1:0] WindowWords = OffW'((slots + 1) * slot_size);
    localparam logic [OffW-1:0] BaseExt     = OffW'(base_addr);

    // Stage 0: combinational decode of the bus request.
    logic [OffW-1:0]     off;
    logic                in_win;
    logic                acc_valid;
    logic                is_hub;
    logic [RegionW-1:0]  region;
    logic [SlotAw-1:0]   word;
    logic [SlotIdxW-1:0] slot_idx;

    // An address below base_addr borrows into the extra top bit.
    assign off       = {1'b0, addr} - BaseExt;
    assign in_win    = !off[OffW-1] && (off < WindowWords);
    assign region    = off[SlotAw +: RegionW];
    assign word      = off[SlotAw-1:0];
    assign acc_valid = enable && in_win;
    assign is_hub    = (region == '0);
    assign slot_idx  = SlotIdxW'(region - RegionW'(1));

    logic                s1_valid_q, s1_valid_d;
    logic                s1_hub_q, s1_hub_d;
    logic                s1_we_q, s1_we_d;
    logic [SlotAw-1:0]   s1_word_q, s1_word_d;
    logic [SlotIdxW-1:0] s1_slot_q, s1_slot_d;
    logic [slots-1:0]    slot_sel_q, slot_sel_d;
    logic [SlotAw-1:0]   slot_addr_q, slot_addr_d;
    logic [wordsize-1:0] slot_wdata_q, slot_wdata_d;
    logic                slot_we_q, slot_we_d;
    logic [wordsize-1:0] data_out_q, data_out_d;
    logic                ready_q, ready_d;

    logic [slots-1:0]    mask_w;
    logic [slots-1:0]    pending_w;
    logic [wordsize-1:0] route0_w;
    logic [wordsize-1:0] route1_w;
    logic [wordsize-1:0] info_w;
    logic [wordsize-1:0] hub_rdata;

    always_comb begin
        s1_valid_d   = acc_valid;
        s1_hub_d     = is_hub;
        s1_we_d      = write_en;
        s1_word_d    = word;
        s1_slot_d    = slot_idx;
        slot_sel_d   = '0;
        slot_addr_d  = '0;
        slot_wdata_d = '0;
        slot_we_d    = 1'b0;
        if (acc_valid && !is_hub) begin
            slot_sel_d   = slots'(1) << slot_idx;
            slot_addr_d  = word;
            slot_wdata_d = data_in;
            slot_we_d    = write_en;
        end
    end

    always_comb begin
        info_w       = '0;
        info_w[15:8] = 8'(slots);
        info_w[7:0]  = 8'(int_lines);
    end

    always_comb begin
        case (s1_word_q)
            SlotAw'(HubRegInfo):    hub_rdata = info_w;
            SlotAw'(HubRegMask):    hub_rdata = wordsize'(mask_w);
            SlotAw'(HubRegPending): hub_rdata = wordsize'(pending_w);
            SlotAw'(HubRegRoute0):  hub_rdata = route0_w;
            SlotAw'(HubRegRoute1):  hub_rdata = route1_w;
            default:                hub_rdata = '0;
        endcase
    end

    // Stage 2: writes pulse ready but leave the last read value in place.
    always_comb begin
        ready_d    = s1_valid_q;
        data_out_d = data_out_q;
        if (s1_valid_q && !s1_we_q) begin
            data_out_d = s1_hub_q ? hub_rdata : slot_rdata[s1_slot_q*wordsize +: wordsize];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid_q   <= 1'b0;
            s1_hub_q     <= 1'b0;
            s1_we_q      <= 1'b0;
            s1_word_q    <= '0;
            s1_slot_q    <= '0;
            slot_sel_q   <= '0;
            slot_addr_q  <= '0;
            slot_wdata_q <= '0;
            slot_we_q    <= 1'b0;
            data_out_q   <= '0;
            ready_q      <= 1'b0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_hub_q     <= s1_hub_d;
            s1_we_q      <= s1_we_d;
            s1_word_q    <= s1_word_d;
            s1_slot_q    <= s1_slot_d;
            slot_sel_q   <= slot_sel_d;
            slot_addr_q  <= slot_addr_d;
            slot_wdata_q <= slot_wdata_d;
            slot_we_q    <= slot_we_d;
            data_out_q   <= data_out_d;
            ready_q      <= ready_d;
        end
    end

`ifdef REFLET_HUB_IRQ_EN
    // Hub register writes land on the same edge that launches stage 1.
    logic hub_wr;
    logic mask_we, pend_w1c, route0_we, route1_we;

    assign hub_wr    = acc_valid && is_hub && write_en;
    assign mask_we   = hub_wr && (word == SlotAw'(HubRegMask));
    assign pend_w1c  = hub_wr && (word == SlotAw'(HubRegPending));
    assign route0_we = hub_wr && (word == SlotAw'(HubRegRoute0));
    assign route1_we = hub_wr && (word == SlotAw'(HubRegRoute1));

    reflet_hub_irq #(
        .Slots    (slots),
        .Width    (wordsize),
        .IntLines (int_lines)
    ) u_irq (
        .clk_i       (clk),
        .rst_ni      (reset),
        .slot_irq_i  (slot_irq),
        .wdata_i     (data_in),
        .mask_we_i   (mask_we),
        .pend_w1c_i  (pend_w1c),
        .route0_we_i (route0_we),
        .route1_we_i (route1_we),
        .mask_o      (mask_w),
        .pending_o   (pending_w),
        .route0_o    (route0_w),
        .route1_o    (route1_w),
        .cpu_int_o   (cpu_int)
    );
`else
    logic unused_slot_irq;

    assign unused_slot_irq = ^slot_irq;
    assign mask_w          = '0;
    assign pending_w       = '0;
    assign route0_w        = '0;
    assign route1_w        = '0;
    assign cpu_int         = '0;
`endif

    assign data_out   = data_out_q;
    assign ready      = ready_q;
    assign slot_sel   = slot_sel_q;
    assign slot_addr  = slot_addr_q;
    assign slot_wdata = slot_wdata_q;
    assign slot_we    = slot_we_q;

endmodule

// File: tb/tb_reflet_periph_hub.sv
// Directed bench for reflet_periph_hub; interrupt expectations follow REFLET_HUB_IRQ_EN.
module tb_reflet_periph_hub;

`ifdef REFLET_HUB_IRQ_EN
    localparam bit IrqEn = 1'b1;
`else
    localparam bit IrqEn = 1'b0;
`endif

    logic         clk      = 1'b0;
    logic         reset    = 1'b1;
    logic         enable   = 1'b0;
    logic         write_en = 1'b0;
    logic [15:0]  addr     = '0;
    logic [15:0]  data_in  = '0;
    logic [7:0]   slot_irq = '0;
    logic [15:0]  data_out;
    logic         ready;
    logic [7:0]   slot_sel;
    logic [2:0]   slot_addr;
    logic [15:0]  slot_wdata;
    logic         slot_we;
    logic [127:0] slot_rdata;
    logic [3:0]   cpu_int;

    int n_cmp = 0;
    int n_bad = 0;

    reflet_periph_hub u_dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .addr       (addr),
        .data_in    (data_in),
        .write_en   (write_en),
        .data_out   (data_out),
        .ready      (ready),
        .slot_sel   (slot_sel),
        .slot_addr  (slot_addr),
        .slot_wdata (slot_wdata),
        .slot_we    (slot_we),
        .slot_rdata (slot_rdata),
        .slot_irq   (slot_irq),
        .cpu_int    (cpu_int)
    );

    always #5 clk = ~clk;

    // Slot s answers 16'hC000 | s<<8 | word offset.
    always_comb begin
        slot_rdata = '0;
        for (int s = 0; s < 8; s++) begin
            slot_rdata[s*16 +: 16] = 16'hC000 | (16'(s) << 8) | 16'(slot_addr);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic access(input logic [15:0] a, input logic w, input logic [15:0] d);
        enable   = 1'b1;
        addr     = a;
        write_en = w;
        data_in  = d;
        cyc();
        enable   = 1'b0;
        write_en = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        #2 reset = 1'b0;
        #1;
        chk("rst_data_out", data_out, 32'h0);
        chk("rst_ready", ready, 32'h0);
        chk("rst_slot_sel", slot_sel, 32'h0);
        chk("rst_slot_we", slot_we, 32'h0);
        chk("rst_cpu_int", cpu_int, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        cyc();

        access(16'hFF00, 1'b0, 16'h0);
        chk("info_s1_ready", ready, 32'h0);
        chk("info_s1_sel", slot_sel, 32'h0);
        cyc();
        chk("info_ready", ready, 32'h1);
        chk("info_data", data_out, 32'h0804);
        cyc();
        chk("info_ready_drop", ready, 32'h0);

        access(16'hFF0B, 1'b1, 16'hA5A5);
        chk("wr_sel", slot_sel, 32'h01);
        chk("wr_addr", slot_addr, 32'h3);
        chk("wr_we", slot_we, 32'h1);
        chk("wr_wdata", slot_wdata, 32'hA5A5);
        cyc();
        chk("wr_sel_drop", slot_sel, 32'h0);
        chk("wr_we_drop", slot_we, 32'h0);
        chk("wr_ready", ready, 32'h1);
        chk("wr_data_hold", data_out, 32'h0804);

        enable = 1'b1;
        addr   = 16'hFF10;
        cyc();
        addr = 16'hFF18;
        chk("b2b_sel1", slot_sel, 32'h02);
        cyc();
        enable = 1'b0;
        chk("b2b_ready1", ready, 32'h1);
        chk("b2b_data1", data_out, 32'hC100);
        chk("b2b_sel2", slot_sel, 32'h04);
        cyc();
        chk("b2b_ready2", ready, 32'h1);
        chk("b2b_data2", data_out, 32'hC200);
        cyc();
        chk("b2b_ready_drop", ready, 32'h0);

        access(16'hFF47, 1'b0, 16'h0);
        chk("last_sel", slot_sel, 32'h80);
        chk("last_addr", slot_addr, 32'h7);
        cyc();
        chk("last_data", data_out, 32'hC707);

        access(16'hFF48, 1'b0, 16'h0);
        chk("above_sel", slot_sel, 32'h0);
        cyc();
        chk("above_ready", ready, 32'h0);
        chk("above_data_hold", data_out, 32'hC707);

        access(16'hFEFF, 1'b0, 16'h0);
        chk("below_sel", slot_sel, 32'h0);
        cyc();
        chk("below_ready", ready, 32'h0);

        access(16'hFF07, 1'b0, 16'h0);
        cyc();
        chk("unmapped_ready", ready, 32'h1);
        chk("unmapped_data", data_out, 32'h0);

        access(16'hFF01, 1'b1, 16'h0004);
        access(16'hFF03, 1'b1, 16'h0030);
        access(16'hFF01, 1'b0, 16'h0);
        cyc();
        chk("mask_rd", data_out, IrqEn ? 32'h0004 : 32'h0);

        slot_irq = 8'h04;
        cyc();
        slot_irq = 8'h00;
        chk("irq_lat1", cpu_int, 32'h0);
        cyc();
        chk("irq_line3", cpu_int, IrqEn ? 32'h8 : 32'h0);

        access(16'hFF02, 1'b1, 16'h0004);
        chk("w1c_lat", cpu_int, IrqEn ? 32'h8 : 32'h0);
        cyc();
        chk("w1c_clear", cpu_int, 32'h0);

        slot_irq = 8'h04;
        access(16'hFF02, 1'b1, 16'h0004);
        access(16'hFF02, 1'b0, 16'h0);
        cyc();
        chk("setwins_pend", data_out, IrqEn ? 32'h0004 : 32'h0);
        chk("setwins_int", cpu_int, IrqEn ? 32'h8 : 32'h0);

        access(16'hFF01, 1'b1, 16'h0000);
        cyc();
        chk("masked_int", cpu_int, 32'h0);
        access(16'hFF02, 1'b0, 16'h0);
        cyc();
        chk("masked_pend", data_out, IrqEn ? 32'h0004 : 32'h0);
        access(16'hFF01, 1'b1, 16'h0004);
        cyc();
        chk("unmask_int", cpu_int, IrqEn ? 32'h8 : 32'h0);
        slot_irq = 8'h00;

        access(16'hFF10, 1'b0, 16'h0);
        chk("mid_s1_sel", slot_sel, 32'h02);
        reset = 1'b0;
        #1;
        chk("mid_rst_data", data_out, 32'h0);
        chk("mid_rst_ready", ready, 32'h0);
        chk("mid_rst_sel", slot_sel, 32'h0);
        chk("mid_rst_int", cpu_int, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        cyc();
        chk("post_rst_ready1", ready, 32'h0);
        cyc();
        chk("post_rst_ready2", ready, 32'h0);
        chk("post_rst_sel", slot_sel, 32'h0);

        access(16'hFF01, 1'b0, 16'h0);
        cyc();
        chk("post_rst_mask", data_out, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
